// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : MEM-stage data memory with RV32I load/store controller.
//            Single-port synchronous-read RAM, sub-word stores done by
//            read-modify-write.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  mem_stall,
  output logic                  access_err
);

  localparam int WORDS = 2 ** (DM_ADDRESS - 2);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MERGE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0]     mem [WORDS];
  logic [DATA_W-1:0]     ram_q;
  logic [DM_ADDRESS-3:0] word_idx;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_wdata;

  logic                  is_store;
  logic                  is_req;
  logic                  misaligned;
  logic                  illegal;
  logic                  bad_access;

  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic [DATA_W-1:0]     load_val;
  logic [DATA_W-1:0]     merged;

  assign word_idx = addr[DM_ADDRESS-1:2];

  // Request decode; a simultaneous read+write is treated as a store.
  always_comb begin
    is_store   = MemWrite;
    is_req     = MemRead | MemWrite;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (func3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = addr[0];
      F3_W:        misaligned = (addr[1:0] != 2'b00);
      default:     illegal    = 1'b1;
    endcase
    if (is_store && func3[2]) begin
      illegal = 1'b1;
    end
    bad_access = misaligned | illegal;
  end

  // Lane selection and extension of the word returned by the RAM.
  always_comb begin
    byte_val = ram_q[{addr[1:0], 3'b000} +: 8];
    half_val = ram_q[{addr[1], 4'b0000} +: 16];
    case (func3)
      F3_B:    load_val = {{24{byte_val[7]}}, byte_val};
      F3_H:    load_val = {{16{half_val[15]}}, half_val};
      F3_W:    load_val = ram_q;
      F3_BU:   load_val = {24'h000000, byte_val};
      F3_HU:   load_val = {16'h0000, half_val};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    merged = ram_q;
    if (func3[0]) begin
      merged[{addr[1], 4'b0000} +: 16] = wr_data[15:0];
    end else begin
      merged[{addr[1:0], 3'b000} +: 8] = wr_data[7:0];
    end
  end

  always_comb begin
    state_nxt  = state;
    ram_we     = 1'b0;
    ram_wdata  = wr_data;
    mem_stall  = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    access_err = 1'b0;

    case (state)
      IDLE: begin
        if (is_req) begin
          if (bad_access) begin
            access_err = 1'b1;
          end else if (is_store) begin
            if (func3 == F3_W) begin
              ram_we = 1'b1;
            end else begin
              mem_stall = 1'b1;
              state_nxt = MERGE;
            end
          end else begin
            mem_stall = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        rd_valid  = 1'b1;
        rd_data   = load_val;
        state_nxt = IDLE;
      end
      MERGE: begin
        ram_we    = 1'b1;
        ram_wdata = merged;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Reset squashes any in-flight write and forces quiet outputs.
    if (reset) begin
      state_nxt  = IDLE;
      ram_we     = 1'b0;
      mem_stall  = 1'b0;
      rd_valid   = 1'b0;
      rd_data    = '0;
      access_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RAM array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[word_idx] <= ram_wdata;
    end
    if (state == IDLE) begin
      ram_q <= mem[word_idx];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Directed self-checking bench for data_mem_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [2:0]  func3;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        mem_stall;
  logic        access_err;

  int n_cmp;
  int n_bad;

  data_mem_ctrl #(
    .DM_ADDRESS(9),
    .DATA_W    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .wr_data   (wr_data),
    .func3     (func3),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .mem_stall (mem_stall),
    .access_err(access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".rd_data"},    rd_data,           32'h0);
    chk({tag, ".rd_valid"},   {31'b0, rd_valid},   32'h0);
    chk({tag, ".mem_stall"},  {31'b0, mem_stall},  32'h0);
    chk({tag, ".access_err"}, {31'b0, access_err}, 32'h0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3,
                          input logic [8:0] a, input logic [31:0] d);
    MemRead  = 1'b0;
    MemWrite = 1'b1;
    func3    = f3;
    addr     = a;
    wr_data  = d;
    @(negedge clk);
    chk({tag, ".stall0"}, {31'b0, mem_stall}, (f3 == 3'b010) ? 32'h0 : 32'h1);
    next_cycle();
    if (f3 != 3'b010) begin
      @(negedge clk);
      chk({tag, ".stall1"}, {31'b0, mem_stall}, 32'h0);
      next_cycle();
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] exp);
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    func3    = f3;
    addr     = a;
    @(negedge clk);
    chk({tag, ".stall0"}, {31'b0, mem_stall}, 32'h1);
    chk({tag, ".valid0"}, {31'b0, rd_valid},  32'h0);
    next_cycle();
    @(negedge clk);
    chk({tag, ".valid1"}, {31'b0, rd_valid},  32'h1);
    chk({tag, ".stall1"}, {31'b0, mem_stall}, 32'h0);
    chk({tag, ".data"},   rd_data,            exp);
    next_cycle();
  endtask

  task automatic do_bad(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [8:0] a);
    MemRead  = rd;
    MemWrite = wr;
    func3    = f3;
    addr     = a;
    wr_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    chk({tag, ".err"},   {31'b0, access_err}, 32'h1);
    chk({tag, ".stall"}, {31'b0, mem_stall},  32'h0);
    chk({tag, ".valid"}, {31'b0, rd_valid},   32'h0);
    next_cycle();
    go_idle();
    @(negedge clk);
    chk({tag, ".after"}, {31'b0, access_err}, 32'h0);
    next_cycle();
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = '0;
    wr_data  = '0;
    func3    = 3'b010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("idle");
    next_cycle();

    do_store("sw10", 3'b010, 9'h010, 32'hDEADBEEF);
    do_load ("lw10", 3'b010, 9'h010, 32'hDEADBEEF);

    do_store("sw20", 3'b010, 9'h020, 32'h00000000);
    do_store("sb23", 3'b000, 9'h023, 32'h00000080);
    do_load ("lw20",  3'b010, 9'h020, 32'h80000000);
    do_load ("lb23",  3'b000, 9'h023, 32'hFFFFFF80);
    do_load ("lbu23", 3'b100, 9'h023, 32'h00000080);

    do_store("sw40", 3'b010, 9'h040, 32'h11223344);
    do_store("sh42", 3'b001, 9'h042, 32'h0000BEEF);
    do_load ("lw40",  3'b010, 9'h040, 32'hBEEF3344);
    do_load ("lh42",  3'b001, 9'h042, 32'hFFFFBEEF);
    do_load ("lhu40", 3'b101, 9'h040, 32'h00003344);
    go_idle();
    next_cycle();

    do_bad("lw41",   1'b1, 1'b0, 3'b010, 9'h041);
    do_bad("sh43",   1'b0, 1'b1, 3'b001, 9'h043);
    do_bad("f3_011", 1'b1, 1'b0, 3'b011, 9'h040);
    do_bad("sbu",    1'b0, 1'b1, 3'b100, 9'h040);
    do_bad("sw42rw", 1'b1, 1'b1, 3'b010, 9'h042);
    do_load("lw40b", 3'b010, 9'h040, 32'hBEEF3344);

    do_store("sw60", 3'b010, 9'h060, 32'hAAAAAAAA);
    MemWrite = 1'b1;
    func3    = 3'b000;
    addr     = 9'h060;
    wr_data  = 32'h00000055;
    @(negedge clk);
    chk("sb60.stall0", {31'b0, mem_stall}, 32'h1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("sb60.rst_stall", {31'b0, mem_stall}, 32'h0);
    chk("sb60.rst_valid", {31'b0, rd_valid},  32'h0);
    next_cycle();
    reset = 1'b0;
    go_idle();
    @(negedge clk);
    chk_quiet("sb60.post");
    next_cycle();
    do_load("lw60", 3'b010, 9'h060, 32'hAAAAAAAA);

    do_store("sw80", 3'b010, 9'h080, 32'h12345678);
    do_load ("lw80", 3'b010, 9'h080, 32'h12345678);
    do_store("sb81", 3'b000, 9'h081, 32'h000000FF);
    do_load ("lw80b", 3'b010, 9'h080, 32'h1234FF78);
    go_idle();
    @(negedge clk);
    chk_quiet("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
